// File: rtl/arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Holds the arbiter state and owner encodings plus a saturating counter helper.
package arb_pkg;

    localparam int CNT_W = 4;
    localparam int LAT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_e;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic [CNT_W-1:0] lim
    );
        return (v >= lim) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Down-counter that times the memory read latency.
// done_o is high while the count sits at zero.
module mem_lat_counter
    import arb_pkg::*;
#(
    parameter int WIDTH = LAT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-port memory.
// One transaction in flight; data port wins ties unless fetch is starving.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  if_req_i,
    input  logic [DATA_WIDTH-1:0] if_addr_i,
    output logic                  if_ready_o,
    output logic                  if_valid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [DATA_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_ready_o,
    output logic                  d_valid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o
);

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(LATENCY - 1);

    arb_state_e            state_q, state_d;
    owner_e                owner_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;
    logic [CNT_W-1:0]      starve_q;

    logic grant_if;
    logic grant_d;
    logic lat_load;
    logic lat_en;
    logic lat_done;
    logic issue;
    logic capture_rd;

    // Fetch overrides the data port only once it has waited long enough.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state_q == IDLE) begin
            if (d_req_i && !(if_req_i && starve_q == STARVE_MAX)) begin
                grant_d = 1'b1;
            end else if (if_req_i) begin
                grant_if = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        lat_load = 1'b0;
        lat_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_if || grant_d) state_d = ISSUE;
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    state_d  = WAIT;
                    lat_load = 1'b1;
                end
            end
            WAIT: begin
                lat_en = 1'b1;
                if (lat_done) state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_lat_counter #(
        .WIDTH(LAT_W)
    ) u_lat (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (lat_load),
        .load_val_i(LAT_LOAD),
        .en_i      (lat_en),
        .done_o    (lat_done)
    );

    assign capture_rd = (state_q == WAIT) && lat_done;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_if) begin
                starve_q <= '0;
            end else if (if_req_i) begin
                starve_q <= sat_inc(starve_q, STARVE_MAX);
            end
            if (grant_d) begin
                owner_q <= OWN_D;
                we_q    <= d_we_i;
                addr_q  <= d_addr_i;
                wdata_q <= d_wdata_i;
            end else if (grant_if) begin
                owner_q <= OWN_IF;
                we_q    <= 1'b0;
                addr_q  <= if_addr_i;
                wdata_q <= '0;
            end
            if (capture_rd) begin
                if (owner_q == OWN_IF) if_rdata_q <= mem_rdata_i;
                else                   d_rdata_q  <= mem_rdata_i;
            end
        end
    end

    assign issue       = (state_q == ISSUE);
    assign mem_en_o    = issue;
    assign mem_we_o    = issue & we_q;
    assign mem_addr_o  = issue ? addr_q  : '0;
    assign mem_wdata_o = issue ? wdata_q : '0;

    assign if_ready_o = grant_if;
    assign d_ready_o  = grant_d;
    assign if_valid_o = (state_q == RESP) && (owner_q == OWN_IF);
    assign d_valid_o  = (state_q == RESP) && (owner_q == OWN_D);
    assign if_rdata_o = if_rdata_q;
    assign d_rdata_o  = d_rdata_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-timeline reference model.
module tb_mem_arbiter;

    localparam int LAT = 2;
    localparam int SL  = 4;
    localparam int DW  = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_ready, if_valid;
    logic [DW-1:0] if_addr, if_rdata;
    logic          d_req, d_we, d_ready, d_valid;
    logic [DW-1:0] d_addr, d_wdata, d_rdata;
    logic          mem_en, mem_we, busy;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic          force_en = 1'b0;
    logic [DW-1:0] force_val = '0;
    logic [DW-1:0] pipe [0:7];

    always #5 clk = ~clk;

    mem_arbiter #(
        .LATENCY(LAT),
        .STARVE_LIMIT(SL),
        .DATA_WIDTH(DW)
    ) dut (
        .clk_i(clk), .rst_i(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .if_ready_o(if_ready), .if_valid_o(if_valid),
        .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_ready_o(d_ready),
        .d_valid_o(d_valid), .d_rdata_o(d_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    function automatic logic [DW-1:0] mem_value(input logic [DW-1:0] a);
        if (force_en) return force_val;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Memory: read data appears LAT cycles after the command, junk otherwise.
    always @(posedge clk) begin
        pipe[0] <= (mem_en && !mem_we) ? mem_value(mem_addr) : $urandom();
        for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[LAT-1];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        if_req = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic test_reset;
        quiet();
        rst_n = 0;
        tick(); tick();
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if ({if_valid, d_valid} !== 2'b00) begin n_bad++; $display("FAIL rst_valid got %b want 00", {if_valid, d_valid}); end
        n_cmp++; if ({mem_en, mem_we} !== 2'b00) begin n_bad++; $display("FAIL rst_mem got %b want 00", {mem_en, mem_we}); end
        n_cmp++; if (if_rdata !== '0 || d_rdata !== '0) begin n_bad++; $display("FAIL rst_rdata got %h/%h want 0", if_rdata, d_rdata); end
        n_cmp++; if (mem_addr !== '0 || mem_wdata !== '0) begin n_bad++; $display("FAIL rst_maddr got %h/%h want 0", mem_addr, mem_wdata); end
        tick();
        rst_n = 1;
    endtask

    task automatic test_fetch_read;
        force_en = 1; force_val = 32'hDEAD_BEEF;
        tick();
        if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        n_cmp++; if ({if_ready, d_ready} !== 2'b10) begin n_bad++; $display("FAIL fr_ready got %b want 10", {if_ready, d_ready}); end
        tick();
        quiet();
        @(negedge clk);
        n_cmp++; if ({mem_en, mem_we} !== 2'b10 || mem_addr !== 32'h100) begin
            n_bad++; $display("FAIL fr_issue got %b %h want 10 100", {mem_en, mem_we}, mem_addr);
        end
        for (int k = 2; k <= 5; k++) begin
            tick();
            @(negedge clk);
            n_cmp++; if (if_valid !== (k == 4)) begin n_bad++; $display("FAIL fr_valid@%0d got %b", k, if_valid); end
            n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL fr_men@%0d got %b want 0", k, mem_en); end
            if (k >= 4) begin
                n_cmp++; if (if_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL fr_rdata@%0d got %h want deadbeef", k, if_rdata); end
            end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fr_busy got %b want 0", busy); end
        force_en = 0;
    endtask

    task automatic test_store;
        tick();
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h1234_5678;
        @(negedge clk);
        n_cmp++; if ({if_ready, d_ready} !== 2'b01) begin n_bad++; $display("FAIL st_ready got %b want 01", {if_ready, d_ready}); end
        tick();
        quiet();
        @(negedge clk);
        n_cmp++; if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 32'h200 || mem_wdata !== 32'h1234_5678) begin
            n_bad++; $display("FAIL st_issue got %b %h %h", {mem_en, mem_we}, mem_addr, mem_wdata);
        end
        n_cmp++; if (d_valid !== 1'b0) begin n_bad++; $display("FAIL st_early got %b want 0", d_valid); end
        tick();
        @(negedge clk);
        n_cmp++; if (d_valid !== 1'b1 || mem_en !== 1'b0) begin n_bad++; $display("FAIL st_valid got %b/%b want 1/0", d_valid, mem_en); end
        n_cmp++; if (d_rdata !== '0) begin n_bad++; $display("FAIL st_rdata got %h want 0", d_rdata); end
        tick();
        @(negedge clk);
        n_cmp++; if (d_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL st_end got %b/%b want 0/0", d_valid, busy); end
    endtask

    task automatic test_simultaneous;
        tick();
        if_req = 1; if_addr = 32'h300;
        d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'hAAAA_5555;
        @(negedge clk);
        n_cmp++; if ({if_ready, d_ready} !== 2'b01) begin n_bad++; $display("FAIL sim_first got %b want 01", {if_ready, d_ready}); end
        tick();
        d_req = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++; if (if_ready !== (k == 3)) begin n_bad++; $display("FAIL sim_if@%0d got %b", k, if_ready); end
            tick();
        end
        if_req = 0;
        @(negedge clk);
        n_cmp++; if (mem_en !== 1'b1 || mem_addr !== 32'h300) begin n_bad++; $display("FAIL sim_issue got %b %h want 1 300", mem_en, mem_addr); end
        for (int k = 5; k <= 8; k++) begin
            tick();
            @(negedge clk);
            n_cmp++; if (if_valid !== (k == 7)) begin n_bad++; $display("FAIL sim_valid@%0d got %b", k, if_valid); end
        end
    endtask

    task automatic test_starvation;
        tick();
        if_req = 1; if_addr = 32'h0000_0803;
        d_req = 1; d_we = 1; d_addr = 32'h900; d_wdata = 32'h0BAD_F00D;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            n_cmp++; if (d_ready !== (c == 0 || c == 3)) begin n_bad++; $display("FAIL stv_d@%0d got %b", c, d_ready); end
            n_cmp++; if (if_ready !== (c == 6)) begin n_bad++; $display("FAIL stv_if@%0d got %b", c, if_ready); end
            tick();
        end
        quiet();
        @(negedge clk);
        n_cmp++; if (mem_addr !== 32'h0000_0803 || mem_we !== 1'b0) begin n_bad++; $display("FAIL stv_addr got %h/%b want 803/0", mem_addr, mem_we); end
        for (int c = 8; c <= 11; c++) tick();
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stv_idle got %b want 0", busy); end
    endtask

    task automatic test_pulse_busy;
        tick();
        d_req = 1; d_we = 0; d_addr = 32'h500;
        @(negedge clk);
        n_cmp++; if (d_ready !== 1'b1) begin n_bad++; $display("FAIL pb_accept got %b want 1", d_ready); end
        tick();
        quiet();
        if_req = 1; if_addr = 32'h600;
        @(negedge clk);
        n_cmp++; if (if_ready !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL pb_busy got %b/%b want 0/1", if_ready, busy); end
        tick();
        if_req = 0;
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            n_cmp++; if (d_valid !== (k == 4)) begin n_bad++; $display("FAIL pb_dv@%0d got %b", k, d_valid); end
            if (k >= 2) begin
                n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL pb_men@%0d got %b want 0", k, mem_en); end
            end
            tick();
        end
        n_cmp++; if (d_rdata !== mem_value(32'h500)) begin n_bad++; $display("FAIL pb_rdata got %h want %h", d_rdata, mem_value(32'h500)); end
        if_req = 1; if_addr = 32'h604;
        d_req = 1; d_we = 1; d_addr = 32'h508; d_wdata = 32'h7;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            n_cmp++; if ({if_ready, d_ready} !== ((c == 0) ? 2'b01 : (c == 3) ? 2'b10 : 2'b00)) begin
                n_bad++; $display("FAIL pb_grant@%0d got %b", c, {if_ready, d_ready});
            end
            tick();
        end
        quiet();
        for (int c = 0; c < 5; c++) tick();
    endtask

    task automatic test_reset_wait;
        tick();
        if_req = 1; if_addr = 32'h700;
        tick();
        quiet();
        tick();
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || mem_en !== 1'b0) begin n_bad++; $display("FAIL rw_wait got %b/%b want 1/0", busy, mem_en); end
        #1 rst_n = 0;
        #1;
        n_cmp++; if ({busy, if_valid, d_valid, mem_en} !== 4'b0000) begin
            n_bad++; $display("FAIL rw_async got %b want 0000", {busy, if_valid, d_valid, mem_en});
        end
        n_cmp++; if (if_rdata !== '0 || d_rdata !== '0) begin n_bad++; $display("FAIL rw_rdata got %h/%h want 0", if_rdata, d_rdata); end
        tick();
        rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            @(negedge clk);
            n_cmp++; if ({if_valid, d_valid, busy} !== 3'b000) begin n_bad++; $display("FAIL rw_post@%0d got %b want 000", k, {if_valid, d_valid, busy}); end
        end
        tick();
        d_req = 1; d_we = 1; d_addr = 32'hA00; d_wdata = 32'h55;
        @(negedge clk);
        n_cmp++; if (d_ready !== 1'b1) begin n_bad++; $display("FAIL rw_acc got %b want 1", d_ready); end
        tick();
        quiet();
        tick();
        @(negedge clk);
        n_cmp++; if (d_valid !== 1'b1) begin n_bad++; $display("FAIL rw_resp got %b want 1", d_valid); end
        tick();
    endtask

    task automatic test_random;
        int free_at = 0, issue_at = -1, resp_at = -1, starve = 0;
        logic own_d = 0, m_we = 0;
        logic [DW-1:0] m_addr = '0, m_wdata = '0, pend = '0;
        logic [DW-1:0] exp_ir = '0, exp_dr = '0;
        logic idle, g_if, g_d, on_iss, on_rsp;
        quiet();
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int c = 0; c < 600; c++) begin
            tick();
            if_req = ($urandom_range(0, 9) < 6);
            d_req = ($urandom_range(0, 9) < 5);
            d_we = $urandom_range(0, 1);
            if_addr = $urandom(); d_addr = $urandom(); d_wdata = $urandom();
            on_iss = (c == issue_at);
            on_rsp = (c == resp_at);
            if (on_rsp && !m_we) begin
                if (own_d) exp_dr = pend;
                else exp_ir = pend;
            end
            idle = (c >= free_at);
            g_d = idle && d_req && !(if_req && starve == SL);
            g_if = idle && if_req && !g_d;
            @(negedge clk);
            n_cmp++; if ({if_ready, d_ready} !== {g_if, g_d}) begin n_bad++; $display("FAIL rnd_ready@%0d got %b want %b", c, {if_ready, d_ready}, {g_if, g_d}); end
            n_cmp++; if (busy !== !idle) begin n_bad++; $display("FAIL rnd_busy@%0d got %b want %b", c, busy, !idle); end
            n_cmp++; if ({mem_en, mem_we} !== {on_iss, on_iss && m_we}) begin n_bad++; $display("FAIL rnd_men@%0d got %b", c, {mem_en, mem_we}); end
            n_cmp++; if (mem_addr !== (on_iss ? m_addr : '0) || mem_wdata !== (on_iss ? m_wdata : '0)) begin
                n_bad++; $display("FAIL rnd_mcmd@%0d got %h %h", c, mem_addr, mem_wdata);
            end
            n_cmp++; if ({if_valid, d_valid} !== {on_rsp && !own_d, on_rsp && own_d}) begin n_bad++; $display("FAIL rnd_valid@%0d got %b", c, {if_valid, d_valid}); end
            n_cmp++; if (if_rdata !== exp_ir || d_rdata !== exp_dr) begin
                n_bad++; $display("FAIL rnd_rdata@%0d got %h/%h want %h/%h", c, if_rdata, d_rdata, exp_ir, exp_dr);
            end
            if (g_if) starve = 0;
            else if (if_req && starve < SL) starve++;
            if (g_if || g_d) begin
                own_d = g_d;
                m_we = g_d && d_we;
                m_addr = g_d ? d_addr : if_addr;
                m_wdata = g_d ? d_wdata : '0;
                issue_at = c + 1;
                resp_at = c + 2 + (m_we ? 0 : LAT);
                free_at = resp_at + 1;
                pend = mem_value(m_addr);
            end
        end
        quiet();
    endtask

    initial begin
        quiet();
        rst_n = 0;
        test_reset();
        test_fetch_read();
        test_store();
        test_simultaneous();
        test_starvation();
        test_pulse_busy();
        test_reset_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
